// File: rtl/rmst_out_fm_fifo_to_buf_if.sv
// Handshake and data bundle between the out_fm FIFO-to-buffer stage,
// its load FIFO and the out_fm tile buffer.
interface rmst_out_fm_fifo_to_buf_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic          load_start;
    logic          load_done;
    logic          busy;
    logic          fifo_empty;
    logic          fifo_pop;
    logic [DW-1:0] fifo_rdata;
    logic          out_fm_wena;
    logic [AW-1:0] out_fm_waddr;
    logic [DW-1:0] out_fm_wdata;

    // Stage side: consumes start/FIFO, produces pops and buffer writes
    modport master (
        input  load_start,
        input  fifo_empty,
        input  fifo_rdata,
        output load_done,
        output busy,
        output fifo_pop,
        output out_fm_wena,
        output out_fm_waddr,
        output out_fm_wdata
    );

    // Environment side: controller, FIFO and buffer
    modport slave (
        output load_start,
        output fifo_empty,
        output fifo_rdata,
        input  load_done,
        input  busy,
        input  fifo_pop,
        input  out_fm_wena,
        input  out_fm_waddr,
        input  out_fm_wdata
    );
endinterface

// File: rtl/rmst_out_fm_fifo_to_buf.sv
// Drains the out_fm load FIFO row by row, drops the tile_offset leading
// words of each row and writes the kept words into the out_fm tile buffer.
module rmst_out_fm_fifo_to_buf #(
    parameter int unsigned AW          = 16,
    parameter int unsigned CW          = 16,
    parameter int unsigned DW          = 32,
    parameter int unsigned Tn          = 16,
    parameter int unsigned Tr          = 64,
    parameter int unsigned Tc          = 16,
    parameter int unsigned tile_offset = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    rmst_out_fm_fifo_to_buf_if.master bus
);
    localparam logic [CW-1:0] TOTAL    = CW'(Tn * Tr * (Tc + tile_offset));
    localparam logic [CW-1:0] COL_LAST = CW'(Tc + tile_offset - 1);
    localparam logic [CW-1:0] TR_LAST  = CW'(Tr - 1);
    localparam logic [CW-1:0] OFF      = CW'(tile_offset);
    localparam logic [CW-1:0] TC_W     = CW'(Tc);
    localparam logic [CW-1:0] TR_TC    = CW'(Tr * Tc);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state_q;
    state_t        state_d;
    logic          start_c;
    logic          pop_c;
    logic          keep_c;
    logic [CW-1:0] word_addr_c;

    logic [CW-1:0] pop_cnt_q;
    logic          rd_valid_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] tr_q;
    logic [CW-1:0] tn_q;
    logic          wena_q;
    logic [AW-1:0] waddr_q;
    logic [DW-1:0] wdata_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; DRAIN waits for the last popped word to leave stage 1
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    state_d = RUN;
                    start_c = 1'b1;
                end
            end
            RUN: begin
                if (pop_cnt_q == TOTAL) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pop_c = (state_q == RUN) && !bus.fifo_empty && (pop_cnt_q < TOTAL);

    // With no leading words every column is kept
    generate
        if (tile_offset == 0) begin : g_keep_all
            assign keep_c = 1'b1;
        end else begin : g_keep_cols
            assign keep_c = (col_q >= OFF);
        end
    endgenerate

    assign word_addr_c = tn_q * TR_TC + tr_q * TC_W + (col_q - OFF);

    // Pop counter, read-valid stage and row/channel position counters
    always_ff @(posedge clk) begin
        if (rst) begin
            pop_cnt_q  <= '0;
            rd_valid_q <= 1'b0;
            col_q      <= '0;
            tr_q       <= '0;
            tn_q       <= '0;
        end else begin
            rd_valid_q <= pop_c;
            if (start_c) begin
                pop_cnt_q <= '0;
                col_q     <= '0;
                tr_q      <= '0;
                tn_q      <= '0;
            end else begin
                if (pop_c) begin
                    pop_cnt_q <= pop_cnt_q + CW'(1);
                end
                if (rd_valid_q) begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        if (tr_q == TR_LAST) begin
                            tr_q <= '0;
                            tn_q <= tn_q + CW'(1);
                        end else begin
                            tr_q <= tr_q + CW'(1);
                        end
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
            end
        end
    end

    // Buffer write stage; address and data hold when no write is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            wena_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else if (rd_valid_q && keep_c) begin
            wena_q  <= 1'b1;
            waddr_q <= AW'(word_addr_c);
            wdata_q <= bus.fifo_rdata;
        end else begin
            wena_q  <= 1'b0;
        end
    end

    assign bus.fifo_pop     = pop_c;
    assign bus.busy         = (state_q != IDLE);
    assign bus.load_done    = (state_q == DONE);
    assign bus.out_fm_wena  = wena_q;
    assign bus.out_fm_waddr = waddr_q;
    assign bus.out_fm_wdata = wdata_q;
endmodule

// File: tb/tb_rmst_out_fm_fifo_to_buf.sv
// Bench for rmst_out_fm_fifo_to_buf: a queue-backed FIFO and an expected-write
// scoreboard derived from tile geometry, for a 2x2x4/offset-2 instance and a
// 1x1x4/offset-0 instance.
module tb_rmst_out_fm_fifo_to_buf;
    localparam int AW      = 16;
    localparam int CW      = 16;
    localparam int DW      = 32;
    localparam int A_TN    = 2;
    localparam int A_TR    = 2;
    localparam int A_TC    = 4;
    localparam int A_OFF   = 2;
    localparam int A_RL    = A_TC + A_OFF;
    localparam int A_TOTAL = A_TN * A_TR * A_RL;
    localparam int B_TC    = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    rmst_out_fm_fifo_to_buf_if #(.AW(AW), .DW(DW)) a_if ();
    rmst_out_fm_fifo_to_buf_if #(.AW(AW), .DW(DW)) b_if ();

    rmst_out_fm_fifo_to_buf #(
        .AW(AW), .CW(CW), .DW(DW), .Tn(A_TN), .Tr(A_TR), .Tc(A_TC), .tile_offset(A_OFF)
    ) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.master)
    );

    rmst_out_fm_fifo_to_buf #(
        .AW(AW), .CW(CW), .DW(DW), .Tn(1), .Tr(1), .Tc(B_TC), .tile_offset(0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.master)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- instance A model ----------------
    logic [DW-1:0] a_fifo_q[$];
    wr_t           a_exp_q[$];
    logic [DW-1:0] a_rdata = '0;
    assign a_if.fifo_rdata = a_rdata;

    bit a_pend_pop   = 1'b0;
    bit a_rst_edge   = 1'b1;
    bit a_force_empty = 1'b0;
    bit a_tog        = 1'b0;
    int a_mode       = 0;
    int a_pops       = 0;
    int a_writes     = 0;
    int a_dones      = 0;
    int a_first_pop_edge = 0;
    int a_last_pop_edge  = -100;

    // Consume one FIFO word and predict its buffer write from tile geometry
    task automatic a_commit_pop();
        int  idx;
        int  ch;
        int  r;
        int  c;
        wr_t e;
        if (a_fifo_q.size() == 0) begin
            check("a_fifo_underflow", 1, 0);
            return;
        end
        a_rdata = a_fifo_q.pop_front();
        idx = a_pops % A_TOTAL;
        ch  = idx / (A_TR * A_RL);
        r   = (idx / A_RL) % A_TR;
        c   = idx % A_RL;
        if (idx == 0) a_first_pop_edge = cyc;
        if (c >= A_OFF) begin
            e.addr = AW'(ch * A_TR * A_TC + r * A_TC + c - A_OFF);
            e.data = a_rdata;
            e.due  = cyc + 1;
            a_exp_q.push_back(e);
        end
        a_pops++;
        a_last_pop_edge = cyc;
    endtask

    task automatic a_monitor();
        wr_t e;
        if (a_if.out_fm_wena) begin
            if (a_exp_q.size() == 0) begin
                check("a_unexpected_write", 1, 0);
            end else begin
                e = a_exp_q.pop_front();
                check("a_waddr", a_if.out_fm_waddr, e.addr);
                check("a_wdata", a_if.out_fm_wdata, e.data);
                check("a_wtime", cyc, e.due);
                a_writes++;
            end
        end else if (a_exp_q.size() > 0 && a_exp_q[0].due <= cyc) begin
            e = a_exp_q.pop_front();
            check("a_missing_write", 0, 1);
        end
        if (a_if.load_done) begin
            a_dones++;
            check("a_done_tile_full", (a_pops > 0) && (a_pops % A_TOTAL == 0), 1);
            check("a_done_time", cyc, a_last_pop_edge + 2);
        end
    endtask

    initial begin : a_fifo_model
        a_if.fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            if (a_rst_edge) begin
                if (a_pend_pop && a_fifo_q.size() > 0) a_rdata = a_fifo_q.pop_front();
                a_exp_q.delete();
                a_pops = 0;
            end else begin
                if (a_pend_pop) a_commit_pop();
                a_monitor();
            end
            a_if.fifo_empty = (a_fifo_q.size() == 0) || a_force_empty ||
                              (a_mode == 1 && a_tog) ||
                              (a_mode == 2 && $urandom_range(0, 99) < 35);
            a_tog = ~a_tog;
            #1;
            a_pend_pop = a_if.fifo_pop;
            a_rst_edge = rst;
            if (a_pend_pop) check("a_pop_while_empty", a_if.fifo_empty, 1'b0);
        end
    end

    // ---------------- instance B model ----------------
    logic [DW-1:0] b_words[8];
    int            b_pop_edge[8];
    logic [DW-1:0] b_rdata = '0;
    assign b_if.fifo_rdata = b_rdata;
    bit b_pend_pop = 1'b0;
    int b_pops  = 0;
    int b_wr    = 0;
    int b_dones = 0;

    initial begin : b_fifo_model
        b_if.fifo_empty = 1'b0;
        forever begin
            @(negedge clk);
            if (b_pend_pop) begin
                if (b_pops < 8) begin
                    b_rdata = b_words[b_pops];
                    b_pop_edge[b_pops] = cyc;
                end
                b_pops++;
            end
            if (b_if.out_fm_wena) begin
                if (b_wr < 4 && b_wr < b_pops) begin
                    check("b_waddr", b_if.out_fm_waddr, AW'(b_wr));
                    check("b_wdata", b_if.out_fm_wdata, b_words[b_wr]);
                    check("b_wtime", cyc, b_pop_edge[b_wr] + 1);
                end else begin
                    check("b_unexpected_write", 1, 0);
                end
                b_wr++;
            end
            if (b_if.load_done) begin
                b_dones++;
                if (b_pops >= 4) check("b_done_time", cyc, b_pop_edge[3] + 2);
                else check("b_done_early", b_pops, 4);
            end
            #1;
            b_pend_pop = b_if.fifo_pop;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic a_load(input int n, input bit seq);
        for (int i = 0; i < n; i++) a_fifo_q.push_back(seq ? DW'(i) : DW'($urandom));
    endtask

    task automatic a_start();
        a_if.load_start = 1'b1;
        @(negedge clk);
        a_if.load_start = 1'b0;
    endtask

    task automatic a_wait_done_pulse();
        int k = 0;
        while (a_if.load_done !== 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("a_done_timeout", a_if.load_done, 1'b1);
    endtask

    task automatic a_wait_pops(input int n);
        int k = 0;
        while (a_pops < n && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("a_pops_timeout", a_pops >= n, 1);
    endtask

    task automatic a_check_idle_outputs(input string tag);
        check({tag, "_load_done"}, a_if.load_done, 0);
        check({tag, "_busy"},      a_if.busy, 0);
        check({tag, "_fifo_pop"},  a_if.fifo_pop, 0);
        check({tag, "_wena"},      a_if.out_fm_wena, 0);
        check({tag, "_waddr"},     a_if.out_fm_waddr, 0);
        check({tag, "_wdata"},     a_if.out_fm_wdata, 0);
    endtask

    // One full tile with the current bubble mode; checks pop/write/done totals
    task automatic a_run_tile(input string tag, input bit seq);
        int p0;
        int w0;
        int d0;
        a_load(A_TOTAL, seq);
        p0 = a_pops;
        w0 = a_writes;
        d0 = a_dones;
        a_start();
        check({tag, "_busy_run"}, a_if.busy, 1);
        a_wait_done_pulse();
        check({tag, "_pops"}, a_pops - p0, A_TOTAL);
        check({tag, "_writes"}, a_writes - w0, A_TN * A_TR * A_TC);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, a_if.load_done, 0);
        check({tag, "_done_count"}, a_dones - d0, 1);
        check({tag, "_busy_idle"}, a_if.busy, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int d0;
        int w0;
        int p0;
        a_if.load_start = 1'b0;
        b_if.load_start = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        a_check_idle_outputs("reset");
        check("reset_b_busy", b_if.busy, 0);
        check("reset_b_wena", b_if.out_fm_wena, 0);
        rst = 1'b0;
        @(negedge clk);

        // Tile of sequential words, FIFO never empty
        a_mode = 0;
        a_run_tile("seq", 1'b1);
        check("seq_pop_span", a_last_pop_edge - a_first_pop_edge, A_TOTAL - 1);

        // FIFO empty every other cycle
        a_mode = 1;
        a_run_tile("toggle", 1'b0);

        // Random bubbles over several tiles
        a_mode = 2;
        for (int t = 0; t < 3; t++) a_run_tile("rand", 1'b0);

        // Stray load_start in RUN and in the load_done cycle, then back-to-back tile
        a_mode = 0;
        a_load(2 * A_TOTAL, 1'b0);
        d0 = a_dones;
        w0 = a_writes;
        p0 = a_pops;
        a_start();
        a_wait_pops(p0 + 5);
        a_if.load_start = 1'b1;
        @(negedge clk);
        a_if.load_start = 1'b0;
        a_wait_done_pulse();
        check("b2b_first_pops", a_pops - p0, A_TOTAL);
        a_if.load_start = 1'b1;
        @(negedge clk);
        check("b2b_idle_after_done", a_if.busy, 0);
        @(negedge clk);
        a_if.load_start = 1'b0;
        check("b2b_second_busy", a_if.busy, 1);
        a_wait_done_pulse();
        @(negedge clk);
        check("b2b_pops", a_pops - p0, 2 * A_TOTAL);
        check("b2b_writes", a_writes - w0, 2 * A_TN * A_TR * A_TC);
        check("b2b_dones", a_dones - d0, 2);

        // Reset mid-tile after 10 pops, then restart from address 0
        a_load(A_TOTAL, 1'b0);
        d0 = a_dones;
        a_start();
        a_wait_pops(10);
        rst = 1'b1;
        @(negedge clk);
        a_check_idle_outputs("midrst");
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_done", a_dones - d0, 0);
        check("midrst_no_pop", a_if.fifo_pop, 0);
        a_fifo_q.delete();
        a_run_tile("restart", 1'b0);

        // FIFO empty throughout: stalls in RUN with nothing happening
        a_fifo_q.delete();
        a_force_empty = 1'b1;
        p0 = a_pops;
        w0 = a_writes;
        d0 = a_dones;
        a_start();
        repeat (20) @(negedge clk);
        check("empty_pops", a_pops - p0, 0);
        check("empty_fifo_pop", a_if.fifo_pop, 0);
        check("empty_busy", a_if.busy, 1);
        check("empty_writes", a_writes - w0, 0);
        check("empty_dones", a_dones - d0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        a_force_empty = 1'b0;
        check("empty_reset_busy", a_if.busy, 0);

        // Zero-offset instance: every word written, 2-cycle latency
        for (int i = 0; i < 8; i++) b_words[i] = DW'($urandom);
        b_if.load_start = 1'b1;
        @(negedge clk);
        b_if.load_start = 1'b0;
        for (int k = 0; k < 100 && b_if.load_done !== 1'b1; k++) @(negedge clk);
        check("b_done_seen", b_if.load_done, 1);
        @(negedge clk);
        check("b_pops", b_pops, B_TC);
        check("b_writes", b_wr, B_TC);
        check("b_dones", b_dones, 1);
        check("b_busy_idle", b_if.busy, 0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
